// File: rtl/crop_max_buffer.sv
// Crop window capture buffer with running maximum, feeding the normalizer.
// Ports: ap_* control, crop_*_start window origin, s_axis in, m_axis out, norm_denominator.
module crop_max_buffer #(
  parameter int IN_ROWS  = 64,
  parameter int IN_COLS  = 64,
  parameter int OUT_ROWS = 10,
  parameter int OUT_COLS = 10
) (
  input  logic                       clk,
  input  logic                       s_axis_resetn,
  input  logic                       ap_start,
  output logic                       ap_ready,
  output logic                       ap_idle,
  output logic                       ap_done,
  input  logic [$clog2(IN_ROWS)-1:0] crop_row_start,
  input  logic [$clog2(IN_COLS)-1:0] crop_col_start,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [7:0]                 s_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [7:0]                 m_axis_tdata,
  output logic [7:0]                 norm_denominator
);

  localparam int RW     = $clog2(IN_ROWS);
  localparam int CW     = $clog2(IN_COLS);
  localparam int NPIX_I = OUT_ROWS * OUT_COLS;
  localparam int AW     = $clog2(NPIX_I);
  localparam int PW     = $clog2(NPIX_I + 1);

  localparam logic [RW-1:0] ROW_LAST = RW'(IN_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IN_COLS - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(IN_ROWS - OUT_ROWS);
  localparam logic [CW-1:0] COL_MAX  = CW'(IN_COLS - OUT_COLS);
  localparam logic [RW:0]   ROW_SPAN = (RW+1)'(OUT_ROWS);
  localparam logic [CW:0]   COL_SPAN = (CW+1)'(OUT_COLS);
  localparam logic [PW-1:0] NPIX     = PW'(NPIX_I);
  localparam logic [PW-1:0] PIX_LAST = PW'(NPIX_I - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic [1:0]    r_state;
  logic [RW-1:0] r_row;
  logic [RW-1:0] r_rs;
  logic [CW-1:0] r_col;
  logic [CW-1:0] r_cs;
  logic [7:0]    r_max;
  logic [7:0]    r_norm;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rd_addr;
  logic [PW-1:0] r_rd_cnt;
  logic [PW-1:0] r_out_cnt;
  logic          r_rd_vld;
  logic [7:0]    r_rdata;
  logic [1:0]    r_cnt;
  logic [7:0]    r_q0;
  logic [7:0]    r_q1;
  logic [7:0]    r_mem [NPIX_I];

  logic [RW-1:0] w_rrel;
  logic [CW-1:0] w_crel;
  logic          w_in_hs;
  logic          w_in_win;
  logic          w_wr;
  logic          w_last_px;
  logic          w_pop;
  logic          w_push;
  logic [1:0]    w_occ;
  logic          w_issue;
  logic [RW-1:0] w_rs_clamp;
  logic [CW-1:0] w_cs_clamp;

  assign w_rrel    = r_row - r_rs;
  assign w_crel    = r_col - r_cs;
  assign w_in_hs   = (r_state == S_CAPTURE) && s_axis_tvalid;
  // The >= guards stop a wrapped offset from looking in-window.
  assign w_in_win  = (r_row >= r_rs) && ({1'b0, w_rrel} < ROW_SPAN) &&
                     (r_col >= r_cs) && ({1'b0, w_crel} < COL_SPAN);
  assign w_wr      = w_in_hs && w_in_win;
  assign w_last_px = (r_row == ROW_LAST) && (r_col == COL_LAST);

  assign w_rs_clamp = (crop_row_start > ROW_MAX) ? ROW_MAX : crop_row_start;
  assign w_cs_clamp = (crop_col_start > COL_MAX) ? COL_MAX : crop_col_start;

  assign w_pop  = (r_cnt != 2'd0) && m_axis_tready;
  assign w_push = r_rd_vld;
  // Reads in flight plus held entries never exceed the 2-entry skid.
  assign w_occ  = r_cnt + {1'b0, r_rd_vld};
  // Read-ahead starts in DONE so the first beat is out two cycles later.
  assign w_issue = ((r_state == S_DONE) || (r_state == S_DRAIN)) &&
                   (r_rd_cnt != NPIX) && ((w_occ != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= s_axis_tdata;
    if (w_issue) r_rdata <= r_mem[r_rd_addr];
  end

  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      r_state   <= S_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_rs      <= '0;
      r_cs      <= '0;
      r_max     <= '0;
      r_norm    <= '0;
      r_wptr    <= '0;
      r_rd_addr <= '0;
      r_rd_cnt  <= '0;
      r_out_cnt <= '0;
      r_rd_vld  <= 1'b0;
      r_cnt     <= '0;
      r_q0      <= '0;
      r_q1      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ap_start) begin
            r_rs      <= w_rs_clamp;
            r_cs      <= w_cs_clamp;
            r_row     <= '0;
            r_col     <= '0;
            r_max     <= '0;
            r_wptr    <= '0;
            r_rd_addr <= '0;
            r_rd_cnt  <= '0;
            r_out_cnt <= '0;
            r_state   <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (w_in_hs) begin
            if (r_col == COL_LAST) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
            if (w_last_px) r_state <= S_DONE;
          end
          if (w_wr) begin
            r_wptr <= r_wptr + 1'b1;
            if (s_axis_tdata > r_max) r_max <= s_axis_tdata;
          end
        end
        S_DONE: begin
          r_norm  <= (r_max == 8'd0) ? 8'd1 : r_max;
          r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_pop && (r_out_cnt == PIX_LAST)) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      r_rd_vld <= w_issue;
      if (w_issue) begin
        r_rd_addr <= r_rd_addr + 1'b1;
        r_rd_cnt  <= r_rd_cnt + 1'b1;
      end
      if (w_pop) r_out_cnt <= r_out_cnt + 1'b1;

      // Head entry r_q0 only changes on a pop or when empty.
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_q0 <= r_rdata;
          else r_q1 <= r_rdata;
          r_cnt <= r_cnt + 1'b1;
        end
        2'b01: begin
          r_q0  <= r_q1;
          r_cnt <= r_cnt - 1'b1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_q0 <= r_rdata;
          end else begin
            r_q0 <= r_q1;
            r_q1 <= r_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign ap_ready         = (r_state == S_IDLE);
  assign ap_idle          = (r_state == S_IDLE);
  assign ap_done          = (r_state == S_DONE);
  assign s_axis_tready    = (r_state == S_CAPTURE);
  assign m_axis_tvalid    = (r_cnt != 2'd0);
  assign m_axis_tdata     = r_q0;
  assign norm_denominator = r_norm;

endmodule

// File: tb/tb_crop_max_buffer.sv
// Scoreboard bench for crop_max_buffer on an 8x8 frame with a 4x4 window.
// Stimulus pushes expected beats; a negedge monitor pops and compares them.
module tb_crop_max_buffer;

  logic       clk = 1'b0;
  logic       s_axis_resetn = 1'b0;
  logic       ap_start = 1'b0;
  logic       ap_ready;
  logic       ap_idle;
  logic       ap_done;
  logic [2:0] crop_row_start = '0;
  logic [2:0] crop_col_start = '0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] s_axis_tdata = '0;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic [7:0] m_axis_tdata;
  logic [7:0] norm_denominator;

  crop_max_buffer #(
    .IN_ROWS(8), .IN_COLS(8), .OUT_ROWS(4), .OUT_COLS(4)
  ) dut (
    .clk(clk),
    .s_axis_resetn(s_axis_resetn),
    .ap_start(ap_start),
    .ap_ready(ap_ready),
    .ap_idle(ap_idle),
    .ap_done(ap_done),
    .crop_row_start(crop_row_start),
    .crop_col_start(crop_col_start),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .norm_denominator(norm_denominator)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int   exp_q[$];
  int   beat_total = 0;
  int   done_total = 0;
  int   done_cyc = 0;
  int   first_lat = -1;
  bit   wait_first = 1'b0;
  bit   prev_v = 1'b0;
  bit   prev_r = 1'b0;
  logic [7:0] prev_d = '0;
  bit   rnd_ready = 1'b0;

  int exp_norm;
  int bb;
  int db;
  int hold_norm;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int pix(input int mode, input int r, input int c);
    case (mode)
      0: return r * 8 + c;
      1: return 0;
      default: return (r == 1 && c == 1) ? 200 : 0;
    endcase
  endfunction

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!s_axis_resetn) begin
        prev_v = 1'b0;
        wait_first = 1'b0;
      end else begin
        if (prev_v && !prev_r)
          chk("stall_hold", {m_axis_tvalid, m_axis_tdata}, {1'b1, prev_d});
        if (ap_done) begin
          done_total++;
          done_cyc = cyc;
          wait_first = 1'b1;
        end else if (wait_first && m_axis_tvalid) begin
          first_lat = cyc - done_cyc;
          wait_first = 1'b0;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          beat_total++;
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL extra_beat actual=%0d required=none", m_axis_tdata);
          end else begin
            chk("beat", m_axis_tdata, exp_q.pop_front());
          end
        end
        prev_v = m_axis_tvalid;
        prev_r = m_axis_tready;
        prev_d = m_axis_tdata;
      end
    end
  end

  task automatic send_frame(input int rs, input int cs, input int mode,
                            input bit gaps, input bit poke);
    int ers;
    int ecs;
    int mx;
    int v;
    ers = (rs > 4) ? 4 : rs;
    ecs = (cs > 4) ? 4 : cs;
    mx = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        v = pix(mode, ers + r, ecs + c);
        exp_q.push_back(v);
        if (v > mx) mx = v;
      end
    exp_norm = (mx == 0) ? 1 : mx;
    crop_row_start = 3'(rs);
    crop_col_start = 3'(cs);
    ap_start = 1'b1;
    @(posedge clk);
    #1;
    ap_start = 1'b0;
    chk("tready_after_start", s_axis_tready, 1);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        if (gaps)
          while ($urandom_range(0, 2) == 0) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk);
            #1;
          end
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 8'(pix(mode, r, c));
        if (poke && r == 2 && c == 0) ap_start = 1'b1;
        @(posedge clk);
        #1;
        ap_start = 1'b0;
      end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!ap_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle"}, ap_ready, 1);
  endtask

  task automatic end_checks(input string nm);
    chk({nm, "_beats"}, beat_total - bb, 16);
    chk({nm, "_done_cnt"}, done_total - db, 1);
    chk({nm, "_norm"}, norm_denominator, exp_norm);
    chk({nm, "_first_lat"}, (first_lat >= 0 && first_lat <= 2), 1);
    chk({nm, "_q_empty"}, exp_q.size(), 0);
  endtask

  task automatic snap();
    bb = beat_total;
    db = done_total;
    first_lat = -1;
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_ready"}, {ap_ready, ap_idle}, 2'b11);
    chk({nm, "_done"}, ap_done, 0);
    chk({nm, "_tready"}, s_axis_tready, 0);
    chk({nm, "_mvalid"}, m_axis_tvalid, 0);
    chk({nm, "_mdata"}, m_axis_tdata, 0);
    chk({nm, "_norm"}, norm_denominator, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    s_axis_resetn = 1'b1;
    @(posedge clk);
    #1;

    snap();
    send_frame(2, 3, 0, 1'b0, 1'b0);
    wait_idle("s1");
    end_checks("s1");

    snap();
    send_frame(7, 7, 0, 1'b0, 1'b0);
    wait_idle("s2");
    end_checks("s2");

    snap();
    send_frame(2, 3, 1, 1'b0, 1'b0);
    wait_idle("s3");
    end_checks("s3");

    snap();
    rnd_ready = 1'b1;
    send_frame(2, 3, 0, 1'b1, 1'b0);
    wait_idle("s4");
    rnd_ready = 1'b0;
    end_checks("s4");

    snap();
    send_frame(2, 3, 0, 1'b0, 1'b0);
    n = 0;
    while (beat_total - bb < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("s5_reach5", (beat_total - bb >= 5), 1);
    #1;
    s_axis_resetn = 1'b0;
    #1;
    reset_checks("s5_rst");
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    s_axis_resetn = 1'b1;
    n = beat_total;
    repeat (3) @(negedge clk);
    chk("s5_no_beats", beat_total - n, 0);
    chk("s5_mvalid_low", m_axis_tvalid, 0);
    @(posedge clk);
    #1;
    snap();
    send_frame(0, 0, 2, 1'b0, 1'b0);
    wait_idle("s5");
    end_checks("s5");

    snap();
    send_frame(7, 7, 0, 1'b0, 1'b1);
    wait_idle("s6a");
    end_checks("s6a");
    hold_norm = exp_norm;
    snap();
    send_frame(0, 4, 0, 1'b0, 1'b0);
    chk("s6_norm_hold", norm_denominator, hold_norm);
    wait_idle("s6b");
    end_checks("s6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
